// File: rtl/store_pkg.sv
// store_pkg: store size encodings and lane-width helper shared by the store path
package store_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    function automatic int lane_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/store_align.sv
// store_align: effective address, lane replication, byte enables and misalign detect
module store_align
    import store_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic [ADDR_W-1:0]   base,
    input  logic [IMM_W-1:0]    imm,
    input  logic [DATA_W-1:0]   data,
    input  logic [1:0]          size,
    output logic [ADDR_W-1:0]   ea,
    output logic [ADDR_W-1:0]   word_addr,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] be,
    output logic                misalign
);
    localparam int NB = DATA_W / 8;
    localparam int LB = lane_bits(DATA_W);

    logic [LB-1:0] lane;

    assign ea        = base + ADDR_W'($signed(imm));
    assign lane      = ea[LB-1:0];
    assign word_addr = {ea[ADDR_W-1:LB], LB'(0)};
    assign wdata     = size == SZ_BYTE ? {NB{data[7:0]}} :
                       size == SZ_HALF ? {(NB/2){data[15:0]}} : data;
    assign be        = size == SZ_BYTE ? NB'(1) << lane :
                       size == SZ_HALF ? NB'(3) << lane : {NB{1'b1}};
    assign misalign  = size == SZ_RSVD || (size == SZ_HALF && ea[0]) ||
                       (size == SZ_WORD && lane != '0);

endmodule

// File: rtl/store_unit.sv
// store_unit: aligned store path with a DEPTH-entry write buffer drained over valid/ready.
// STORE_COALESCE_EN merges same-word stores into the tail entry when the head is not the tail.
module store_unit
    import store_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int IMM_W  = 16,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_base,
    input  logic [IMM_W-1:0]    req_imm,
    input  logic [DATA_W-1:0]   req_data,
    input  logic [1:0]          req_size,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    output logic                fault,
    output logic [ADDR_W-1:0]   fault_addr,
    output logic                empty
);
    localparam int NB = DATA_W / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [NB-1:0]     be;
    } entry_t;

    entry_t            fifo [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_nxt;
    logic [ADDR_W-1:0] ea, word_addr;
    logic [DATA_W-1:0] wdata;
    logic [NB-1:0]     be;
    logic              misalign, accept, push, pop, merge;

    store_align #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMM_W(IMM_W)) u_align (
        .base      (req_base),
        .imm       (req_imm),
        .data      (req_data),
        .size      (req_size),
        .ea        (ea),
        .word_addr (word_addr),
        .wdata     (wdata),
        .be        (be),
        .misalign  (misalign)
    );

    assign req_ready = count < CW'(DEPTH);
    assign mem_valid = count != '0;
    assign accept    = req_valid && req_ready;
    assign pop       = mem_valid && mem_ready;
    assign mem_addr  = fifo[rd_ptr].addr;
    assign mem_wdata = fifo[rd_ptr].data;
    assign mem_be    = fifo[rd_ptr].be;

`ifdef STORE_COALESCE_EN
    logic [PW-1:0]     tail_ptr;
    logic [DATA_W-1:0] merge_data;
    assign tail_ptr = wr_ptr - PW'(1);
    // count >= 2 keeps the bus-visible head untouched by a merge
    assign merge = accept && !misalign && count >= CW'(2) && fifo[tail_ptr].addr == word_addr;
    always_comb begin
        merge_data = fifo[tail_ptr].data;
        for (int i = 0; i < NB; i++)
            merge_data[8*i +: 8] = be[i] ? wdata[8*i +: 8] : fifo[tail_ptr].data[8*i +: 8];
    end
`else
    assign merge = 1'b0;
`endif

    assign push      = accept && !misalign && !merge;
    assign count_nxt = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            empty      <= 1'b1;
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            count <= count_nxt;
            empty <= count_nxt == '0;
            fault <= accept && misalign;
            if (accept && misalign) fault_addr <= ea;
            if (push) begin
                fifo[wr_ptr] <= '{addr: word_addr, data: wdata, be: be};
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
`ifdef STORE_COALESCE_EN
            if (merge) begin
                fifo[tail_ptr].data <= merge_data;
                fifo[tail_ptr].be   <= fifo[tail_ptr].be | be;
            end
`endif
        end
    end

endmodule
